// File: rtl/vbus_arbiter.sv
// vbus_arbiter: owns the shared video-RAM bus and picks its owner each cycle.
// Scanout always wins. DMA and CPU share the remaining cycles: DMA may hold
// the bus for at most MAX_DMA_BURST consecutive cycles while a CPU request is
// waiting, after which one CPU access of CPU_HOLD cycles is inserted.
//
// Ports:
//   i_clk          system clock, all state changes on posedge
//   i_rst          synchronous active-high reset
//   i_scan_req     scanout needs the bus next cycle
//   i_dma_active   DMA has work pending
//   i_cpu_req      level request for one CPU VRAM access, held until ack
//   o_free_vbus_b  low = DMA owns the bus this cycle
//   o_scan_grant   scanout owns the bus this cycle
//   o_cpu_grant    CPU owns the bus this cycle
//   o_cpu_ack      high during the last CPU-owned cycle of an access
//   o_owner        VRAM mux select: 00 idle, 01 scan, 10 dma, 11 cpu
module vbus_arbiter #(
   parameter int unsigned MAX_DMA_BURST = 16,
   parameter int unsigned CPU_HOLD      = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_scan_req,
   input  logic       i_dma_active,
   input  logic       i_cpu_req,
   output logic       o_free_vbus_b,
   output logic       o_scan_grant,
   output logic       o_cpu_grant,
   output logic       o_cpu_ack,
   output logic [1:0] o_owner
);

   localparam int unsigned BURST_W = 8;
   localparam int unsigned REM_W   = 3;

   localparam logic [1:0] OWN_IDLE = 2'b00;
   localparam logic [1:0] OWN_SCAN = 2'b01;
   localparam logic [1:0] OWN_DMA  = 2'b10;
   localparam logic [1:0] OWN_CPU  = 2'b11;

   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DMA_BURST);
   localparam logic [REM_W-1:0]   REM_LOAD  = REM_W'(CPU_HOLD);

   logic [1:0]         owner_q, owner_d;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic [REM_W-1:0]   rem_q, rem_d;
   logic [REM_W-1:0]   rem_eff;
   logic               ack_d;
   logic               ack_edge;
   logic               cpu_may_start;

   // State and decoded output registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         owner_q       <= OWN_IDLE;
         burst_q       <= '0;
         rem_q         <= '0;
         o_owner       <= OWN_IDLE;
         o_free_vbus_b <= 1'b1;
         o_scan_grant  <= 1'b0;
         o_cpu_grant   <= 1'b0;
         o_cpu_ack     <= 1'b0;
      end else begin
         owner_q       <= owner_d;
         burst_q       <= burst_d;
         rem_q         <= rem_d;
         o_owner       <= owner_d;
         o_free_vbus_b <= (owner_d != OWN_DMA);
         o_scan_grant  <= (owner_d == OWN_SCAN);
         o_cpu_grant   <= (owner_d == OWN_CPU);
         o_cpu_ack     <= ack_d;
      end
   end

   // Owner decision, first matching rule wins
   always_comb begin
      owner_d       = OWN_IDLE;
      burst_d       = burst_q;
      rem_d         = rem_q;
      ack_d         = 1'b0;
      ack_edge      = o_cpu_ack;
      // The CPU cycle that just finished consumes one unit of the access.
      rem_eff       = ((owner_q == OWN_CPU) && (rem_q != '0)) ? rem_q - REM_W'(1) : rem_q;
      cpu_may_start = i_cpu_req && !ack_edge && (!i_dma_active || (burst_q == BURST_MAX));

      if (i_scan_req) begin
         owner_d = OWN_SCAN;
         rem_d   = rem_eff;
      end else if (rem_eff != '0) begin
         owner_d = OWN_CPU;
         rem_d   = rem_eff;
      end else if (cpu_may_start) begin
         owner_d = OWN_CPU;
         rem_d   = REM_LOAD;
         burst_d = '0;
      end else if (i_dma_active) begin
         owner_d = OWN_DMA;
         rem_d   = '0;
         // Burst length only matters while a CPU request is waiting.
         if (!i_cpu_req)
            burst_d = '0;
         else if (burst_q >= BURST_MAX)
            burst_d = BURST_MAX;
         else
            burst_d = burst_q + BURST_W'(1);
      end else begin
         owner_d = OWN_IDLE;
         rem_d   = '0;
         burst_d = '0;
      end

      // Ack marks the final CPU cycle; deferred if scan took that slot.
      ack_d = (owner_d == OWN_CPU) && (rem_d == REM_W'(1));
   end

   a_one_grant : assert property (@(posedge i_clk) disable iff (i_rst)
      $onehot0({o_scan_grant, o_cpu_grant, !o_free_vbus_b}));

   a_ack_in_cpu : assert property (@(posedge i_clk) disable iff (i_rst)
      o_cpu_ack |-> o_cpu_grant);

endmodule

// File: tb/tb_vbus_arbiter.sv
// tb_vbus_arbiter: directed scoreboard bench for vbus_arbiter.
// Each step drives one cycle of inputs and queues the owner/ack expected in
// the following cycle; a monitor pops and compares after every clock edge.
module tb_vbus_arbiter;

   localparam int unsigned MAX_BURST = 4;
   localparam int unsigned HOLD      = 2;

   localparam logic [1:0] O_IDLE = 2'b00;
   localparam logic [1:0] O_SCAN = 2'b01;
   localparam logic [1:0] O_DMA  = 2'b10;
   localparam logic [1:0] O_CPU  = 2'b11;

   typedef struct {
      logic [1:0] owner;
      logic       ack;
      string      tag;
   } exp_t;

   logic       i_clk;
   logic       i_rst;
   logic       i_scan_req;
   logic       i_dma_active;
   logic       i_cpu_req;
   logic       o_free_vbus_b;
   logic       o_scan_grant;
   logic       o_cpu_grant;
   logic       o_cpu_ack;
   logic [1:0] o_owner;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   vbus_arbiter #(
      .MAX_DMA_BURST(MAX_BURST),
      .CPU_HOLD     (HOLD)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_scan_req   (i_scan_req),
      .i_dma_active (i_dma_active),
      .i_cpu_req    (i_cpu_req),
      .o_free_vbus_b(o_free_vbus_b),
      .o_scan_grant (o_scan_grant),
      .o_cpu_grant  (o_cpu_grant),
      .o_cpu_ack    (o_cpu_ack),
      .o_owner      (o_owner)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Drive one cycle of inputs and queue the outcome expected after the edge
   task automatic step(input logic rst, input logic scan, input logic dma, input logic cpu,
                       input logic [1:0] own, input logic ack, input string tag);
      exp_t e;
      @(negedge i_clk);
      i_rst        = rst;
      i_scan_req   = scan;
      i_dma_active = dma;
      i_cpu_req    = cpu;
      e.owner = own;
      e.ack   = ack;
      e.tag   = tag;
      exp_q.push_back(e);
   endtask

   // Monitor: compare every output against the queued expectation
   initial begin
      exp_t       e;
      logic [5:0] got;
      logic [5:0] want;
      forever begin
         @(posedge i_clk);
         #1;
         if (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            got  = {o_owner, o_free_vbus_b, o_scan_grant, o_cpu_grant, o_cpu_ack};
            want = {e.owner, (e.owner != O_DMA), (e.owner == O_SCAN), (e.owner == O_CPU), e.ack};
            n_vec++;
            if (got !== want) begin
               n_bad++;
               $display("FAIL %s: owner/free_b/scan/cpu/ack got %b want %b", e.tag, got, want);
            end
         end
      end
   end

   initial begin
      i_rst        = 1'b1;
      i_scan_req   = 1'b0;
      i_dma_active = 1'b0;
      i_cpu_req    = 1'b0;

      // Reset state
      step(1, 0, 0, 0, O_IDLE, 0, "reset0");
      step(1, 0, 1, 1, O_IDLE, 0, "reset1");

      // Reset during the first CPU cycle drops the access without an ack
      step(0, 0, 0, 1, O_CPU,  0, "rstmid_start");
      step(1, 0, 0, 1, O_IDLE, 0, "rstmid_reset");
      step(0, 0, 0, 0, O_IDLE, 0, "rstmid_noresume");
      step(0, 0, 0, 0, O_IDLE, 0, "rstmid_idle");

      // CPU only, request held through the ack edge
      step(0, 0, 0, 1, O_CPU,  0, "cpu_c1");
      step(0, 0, 0, 1, O_CPU,  1, "cpu_c2_ack");
      step(0, 0, 0, 1, O_IDLE, 0, "cpu_nodup");
      step(0, 0, 0, 0, O_IDLE, 0, "cpu_idle");

      // DMA vs CPU fairness: 4 DMA, 2 CPU, repeated
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 4; i++)
            step(0, 0, 1, 1, O_DMA, 0, $sformatf("fair_r%0d_dma%0d", r, i));
         step(0, 0, 1, 1, O_CPU, 0, $sformatf("fair_r%0d_cpu1", r));
         step(0, 0, 1, 1, O_CPU, 1, $sformatf("fair_r%0d_cpu2", r));
      end
      step(0, 0, 0, 0, O_IDLE, 0, "fair_end");

      // Scan preempts the first CPU cycle for 3 cycles
      step(0, 0, 0, 1, O_CPU,  0, "pre_cpu1");
      step(0, 1, 0, 1, O_SCAN, 0, "pre_scan1");
      step(0, 1, 0, 1, O_SCAN, 0, "pre_scan2");
      step(0, 1, 0, 1, O_SCAN, 0, "pre_scan3");
      step(0, 0, 0, 1, O_CPU,  1, "pre_cpu2_ack");
      step(0, 0, 0, 1, O_IDLE, 0, "pre_nodup");
      step(0, 0, 0, 0, O_IDLE, 0, "pre_idle");

      // Scan steals the final CPU cycle: ack deferred to the resumed cycle
      step(0, 0, 0, 1, O_CPU,  0, "defer_cpu1");
      step(0, 1, 0, 1, O_SCAN, 0, "defer_scan");
      step(0, 0, 0, 1, O_CPU,  1, "defer_cpu2_ack");
      step(0, 0, 0, 0, O_IDLE, 0, "defer_idle");

      // Scan vs DMA, no CPU request
      for (int k = 0; k < 20; k++) begin
         if (k >= 5 && k <= 9)
            step(0, 1, 1, 0, O_SCAN, 0, $sformatf("sdma_%0d", k));
         else
            step(0, 0, 1, 0, O_DMA, 0, $sformatf("sdma_%0d", k));
      end
      step(0, 0, 0, 0, O_IDLE, 0, "sdma_idle");

      // Scan mid-burst freezes burst count; all three requesting -> scan
      step(0, 0, 1, 1, O_DMA,  0, "frz_dma1");
      step(0, 0, 1, 1, O_DMA,  0, "frz_dma2");
      step(0, 1, 1, 1, O_SCAN, 0, "frz_scan1");
      step(0, 1, 1, 1, O_SCAN, 0, "frz_scan2");
      step(0, 0, 1, 1, O_DMA,  0, "frz_dma3");
      step(0, 0, 1, 1, O_DMA,  0, "frz_dma4");
      step(0, 0, 1, 1, O_CPU,  0, "frz_cpu1");
      step(0, 0, 0, 1, O_CPU,  1, "frz_cpu2");
      step(0, 0, 0, 0, O_IDLE, 0, "frz_idle");

      // DMA goes inactive mid-burst: CPU takes over, or bus goes idle
      step(0, 0, 1, 1, O_DMA,  0, "drop_dma");
      step(0, 0, 0, 1, O_CPU,  0, "drop_cpu1");
      step(0, 0, 0, 1, O_CPU,  1, "drop_cpu2");
      step(0, 0, 1, 0, O_DMA,  0, "drop_dma_only");
      step(0, 0, 0, 0, O_IDLE, 0, "drop_idle");

      // Long DMA without CPU: burst count must stay at zero
      for (int k = 0; k < 300; k++)
         step(0, 0, 1, 0, O_DMA, 0, $sformatf("long_%0d", k));
      for (int i = 0; i < 4; i++)
         step(0, 0, 1, 1, O_DMA, 0, $sformatf("long_burst%0d", i));
      step(0, 0, 1, 1, O_CPU,  0, "long_cpu1");
      step(0, 0, 0, 1, O_CPU,  1, "long_cpu2");
      step(0, 0, 0, 0, O_IDLE, 0, "long_idle");

      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 4 && exp_q.size() > 0; i++)
         @(posedge i_clk);
      #2;
      if (exp_q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
